// File: rtl/spi_mem_pkg.sv
// ============================================================================
// Module      : spi_mem_pkg
// Description : Shared opcodes, FSM state encoding and status-register layout
//               for the SPI slave memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_mem_pkg;

    // Command opcodes recognised in the first byte of a transaction
    localparam logic [7:0] c_OP_WRITE = 8'h02;
    localparam logic [7:0] c_OP_READ  = 8'h03;
    localparam logic [7:0] c_OP_WRDI  = 8'h04;
    localparam logic [7:0] c_OP_RDSR  = 8'h05;
    localparam logic [7:0] c_OP_WREN  = 8'h06;
    localparam logic [7:0] c_OP_FREAD = 8'h0B;

    // Status register bit positions
    localparam int c_SR_WIP = 0;
    localparam int c_SR_WEL = 1;

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DUMMY  = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_STATUS = 3'd5,
        ST_IGNORE = 3'd6
    } state_e;

    // Status byte as returned by RDSR; WIP is always 0 (writes are immediate)
    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] sb;
        sb           = 8'h00;
        sb[c_SR_WEL] = wel;
        sb[c_SR_WIP] = 1'b0;
        return sb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mem_array.sv
// ============================================================================
// Module      : spi_mem_array
// Description : DEPTH x 8 byte array, one write port on the SCLK rising edge
//               and one asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_mem_array #(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] INIT_BYTE  = 8'hCA
) (
    input  logic                  spi_sclk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [7:0]            wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [7:0]            rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Power-up content; the array itself is never reset
    logic [7:0] mem_q [DEPTH] = '{default: INIT_BYTE};

    // Byte write, committed on the rising edge that samples the last bit
    always_ff @(posedge spi_sclk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/spi_slave_mem.sv
// ============================================================================
// Module      : spi_slave_mem
// Description : SPI mode-0 slave memory (READ, FAST_READ, WRITE, RDSR, WREN,
//               WRDI) running entirely in the SCLK domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_mem #(
    parameter int         ADDR_BYTES  = 2,
    parameter int         ADDR_WIDTH  = 10,
    parameter int         DUMMY_BYTES = 1,
    parameter logic [7:0] INIT_BYTE   = 8'hCA
) (
    input  logic spi_sclk_i,
    input  logic spi_rst_n_i,
    input  logic spi_cs_i,
    input  logic spi_mosi_i,
    output logic spi_miso_o,
    output logic spi_miso_oe_o,
    output logic wel_o
);

    import spi_mem_pkg::*;

    localparam logic [1:0] c_LAST_ADDR  = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] c_LAST_DUMMY = 2'((DUMMY_BYTES > 0) ? (DUMMY_BYTES - 1) : 0);

    // Session reset: power-on reset or chip-select deassertion
    logic w_sess_rst_n;
    assign w_sess_rst_n = spi_rst_n_i & ~spi_cs_i;

    // Receive side (rising edge)
    state_e                state_q;
    logic [2:0]            bit_cnt_q;
    logic [1:0]            byte_cnt_q;
    logic [6:0]            shift_q;
    logic [7:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wel_q;

    // Transmit side (falling edge)
    logic                  miso_q;
    logic                  oe_q;
    logic [6:0]            tx_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;

    logic [7:0]            w_rx_byte;
    logic                  w_byte_end;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [7:0]            w_rd_data;
    logic [7:0]            w_status;

    assign w_rx_byte  = {shift_q, spi_mosi_i};
    assign w_byte_end = (bit_cnt_q == 3'd7);
    assign w_mem_we   = (state_q == ST_WRITE) && w_byte_end;
    assign w_status   = status_byte(wel_q);
    // First byte of a burst comes from the received address, later bytes
    // from the incremented read pointer
    assign w_rd_addr  = oe_q ? (rd_ptr_q + ADDR_WIDTH'(1)) : addr_q;

    spi_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_BYTE  (INIT_BYTE)
    ) u_array (
        .spi_sclk_i (spi_sclk_i),
        .we_i       (w_mem_we),
        .waddr_i    (addr_q),
        .wdata_i    (w_rx_byte),
        .raddr_i    (w_rd_addr),
        .rdata_o    (w_rd_data)
    );

    // Command FSM: bit/byte counting and phase sequencing on MOSI samples
    always_ff @(posedge spi_sclk_i or negedge w_sess_rst_n) begin
        if (!w_sess_rst_n) begin
            state_q    <= ST_CMD;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 7'd0;
            op_q       <= 8'h00;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            shift_q   <= w_rx_byte[6:0];
            case (state_q)
                ST_CMD: begin
                    if (w_byte_end) begin
                        op_q <= w_rx_byte;
                        case (w_rx_byte)
                            c_OP_READ, c_OP_FREAD, c_OP_WRITE: state_q <= ST_ADDR;
                            c_OP_RDSR:                         state_q <= ST_STATUS;
                            default:                           state_q <= ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (w_byte_end) begin
                        if (byte_cnt_q == c_LAST_ADDR) begin
                            byte_cnt_q <= 2'd0;
                            if (op_q == c_OP_READ) begin
                                state_q <= ST_READ;
                            end else if (op_q == c_OP_FREAD) begin
                                state_q <= (DUMMY_BYTES > 0) ? ST_DUMMY : ST_READ;
                            end else begin
                                state_q <= wel_q ? ST_WRITE : ST_IGNORE;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (w_byte_end) begin
                        if (byte_cnt_q == c_LAST_DUMMY) begin
                            byte_cnt_q <= 2'd0;
                            state_q    <= ST_READ;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    // Address register and write-enable latch; both survive CS deassertion
    always_ff @(posedge spi_sclk_i or negedge spi_rst_n_i) begin
        if (!spi_rst_n_i) begin
            addr_q <= '0;
            wel_q  <= 1'b0;
        end else begin
            if (state_q == ST_ADDR) begin
                addr_q <= ADDR_WIDTH'({addr_q, spi_mosi_i});
            end else if (w_mem_we) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
            end
            if ((state_q == ST_CMD) && w_byte_end && (w_rx_byte == c_OP_WREN)) begin
                wel_q <= 1'b1;
            end else if ((state_q == ST_CMD) && w_byte_end && (w_rx_byte == c_OP_WRDI)) begin
                wel_q <= 1'b0;
            end else if (w_mem_we) begin
                wel_q <= 1'b0;
            end
        end
    end

    // MISO shifter: load a fresh byte at each byte boundary, else shift
    always_ff @(negedge spi_sclk_i or negedge w_sess_rst_n) begin
        if (!w_sess_rst_n) begin
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            tx_q     <= 7'd0;
            rd_ptr_q <= '0;
        end else if ((state_q == ST_READ) || (state_q == ST_STATUS)) begin
            if (bit_cnt_q == 3'd0) begin
                oe_q <= 1'b1;
                if (state_q == ST_READ) begin
                    miso_q   <= w_rd_data[7];
                    tx_q     <= w_rd_data[6:0];
                    rd_ptr_q <= w_rd_addr;
                end else begin
                    miso_q <= w_status[7];
                    tx_q   <= w_status[6:0];
                end
            end else begin
                miso_q <= tx_q[6];
                tx_q   <= {tx_q[5:0], 1'b0};
            end
        end else begin
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = oe_q;
    assign wel_o         = wel_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_mem.sv
// ============================================================================
// Module      : tb_spi_slave_mem
// Description : Directed, table-driven bench for spi_slave_mem acting as an
//               SPI mode-0 master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_mem;

    logic sclk;
    logic rst_n;
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oe;
    logic wel;

    int n_checks;
    int n_fail;

    spi_slave_mem #(
        .ADDR_BYTES  (2),
        .ADDR_WIDTH  (10),
        .DUMMY_BYTES (1),
        .INIT_BYTE   (8'hCA)
    ) dut (
        .spi_sclk_i    (sclk),
        .spi_rst_n_i   (rst_n),
        .spi_cs_i      (cs),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (miso_oe),
        .wel_o         (wel)
    );

    // One transaction: up to 8 bytes, left-aligned in 64-bit fields.
    // wel: 0/1 expected after CS rise, 2 = not checked
    typedef struct packed {
        logic [3:0]  n;
        logic [63:0] tx;
        logic [3:0]  chk;
        logic [63:0] exp;
        logic        exp_oe;
        logic [1:0]  wel;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Drive one bit in the low phase, sample MISO just before the rising edge
    task automatic bit_x(input logic b, output logic m, output logic o);
        mosi = b;
        #3;
        m    = miso;
        o    = miso_oe;
        sclk = 1'b1;
        #5;
        sclk = 1'b0;
        #2;
    endtask

    task automatic byte_x(input logic [7:0] tx, output logic [7:0] rx, output logic oe0);
        logic m;
        logic o;
        oe0 = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bit_x(tx[i], m, o);
            rx[i] = m;
            if (i == 7) oe0 = o;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        #5;
    endtask

    task automatic cs_high();
        #3;
        cs = 1'b1;
        #10;
    endtask

    task automatic xfer(input int n, input logic [63:0] tx, output logic [63:0] rx, output logic [7:0] oe_first);
        logic [7:0] b;
        logic       o;
        rx       = '0;
        oe_first = '0;
        cs_low();
        for (int i = 0; i < n; i++) begin
            byte_x(tx[63-8*i -: 8], b, o);
            rx[63-8*i -: 8] = b;
            oe_first[i]     = o;
        end
        cs_high();
    endtask

    function automatic vec_t mk(input int n, input logic [63:0] tx, input int chk,
                                input logic [63:0] expv, input logic eoe, input logic [1:0] w);
        vec_t v;
        v.n      = 4'(n);
        v.tx     = tx;
        v.chk    = 4'(chk);
        v.exp    = expv;
        v.exp_oe = eoe;
        v.wel    = w;
        return v;
    endfunction

    initial begin
        logic [63:0] rx;
        logic [7:0]  oef;
        logic [7:0]  b;
        logic        o;
        logic        m;

        n_checks = 0;
        n_fail   = 0;

        // n, tx bytes, first checked byte, expected bytes, expected oe, wel
        vecs[0]  = mk(3, 64'h05_00_00_00_00_00_00_00, 1, 64'h00_00_00_00_00_00_00_00, 1'b1, 2'd0); // RDSR after reset
        vecs[1]  = mk(4, 64'h02_00_10_A5_00_00_00_00, 4, 64'h0,                        1'b1, 2'd0); // WRITE without WEL
        vecs[2]  = mk(4, 64'h03_00_10_00_00_00_00_00, 3, 64'h00_00_00_CA_00_00_00_00, 1'b1, 2'd0); // unchanged
        vecs[3]  = mk(1, 64'h06_00_00_00_00_00_00_00, 1, 64'h0,                        1'b1, 2'd1); // WREN
        vecs[4]  = mk(3, 64'h05_00_00_00_00_00_00_00, 1, 64'h00_02_02_00_00_00_00_00, 1'b1, 2'd1); // RDSR shows WEL
        vecs[5]  = mk(5, 64'h02_00_10_A5_5A_00_00_00, 5, 64'h0,                        1'b1, 2'd0); // WRITE burst
        vecs[6]  = mk(5, 64'h03_00_10_00_00_00_00_00, 3, 64'h00_00_00_A5_5A_00_00_00, 1'b1, 2'd0);
        vecs[7]  = mk(5, 64'h03_FC_10_00_00_00_00_00, 3, 64'h00_00_00_A5_5A_00_00_00, 1'b1, 2'd0); // upper bits ignored
        vecs[8]  = mk(1, 64'h06_00_00_00_00_00_00_00, 1, 64'h0,                        1'b1, 2'd1);
        vecs[9]  = mk(5, 64'h02_03_FF_11_22_00_00_00, 5, 64'h0,                        1'b1, 2'd0); // write wrap
        vecs[10] = mk(5, 64'h03_FF_FF_00_00_00_00_00, 3, 64'h00_00_00_11_22_00_00_00, 1'b1, 2'd0); // read wrap
        vecs[11] = mk(6, 64'h0B_00_10_00_00_00_00_00, 4, 64'h00_00_00_00_A5_5A_00_00, 1'b1, 2'd0); // FAST_READ
        vecs[12] = mk(5, 64'h03_00_0F_00_00_00_00_00, 3, 64'h00_00_00_CA_A5_00_00_00, 1'b1, 2'd0);
        vecs[13] = mk(1, 64'h06_00_00_00_00_00_00_00, 1, 64'h0,                        1'b1, 2'd1);
        vecs[14] = mk(1, 64'h04_00_00_00_00_00_00_00, 1, 64'h0,                        1'b1, 2'd0); // WRDI
        vecs[15] = mk(3, 64'h05_00_00_00_00_00_00_00, 1, 64'h00_00_00_00_00_00_00_00, 1'b1, 2'd0);
        vecs[16] = mk(3, 64'h9F_00_00_00_00_00_00_00, 1, 64'h00_00_00_00_00_00_00_00, 1'b0, 2'd0); // unknown opcode

        sclk  = 1'b0;
        cs    = 1'b1;
        mosi  = 1'b0;
        rst_n = 1'b0;
        #10;
        check("reset miso", 32'(miso), 32'd0);
        check("reset oe",   32'(miso_oe), 32'd0);
        check("reset wel",  32'(wel), 32'd0);
        rst_n = 1'b1;
        #10;

        for (int v = 0; v < NVEC; v++) begin
            xfer(int'(vecs[v].n), vecs[v].tx, rx, oef);
            for (int i = int'(vecs[v].chk); i < int'(vecs[v].n); i++) begin
                check($sformatf("vec%0d byte%0d data", v, i), 32'(rx[63-8*i -: 8]), 32'(vecs[v].exp[63-8*i -: 8]));
                check($sformatf("vec%0d byte%0d oe", v, i), 32'(oef[i]), 32'(vecs[v].exp_oe));
            end
            if (vecs[v].wel != 2'd2) begin
                check($sformatf("vec%0d wel", v), 32'(wel), 32'(vecs[v].wel[0]));
            end
        end

        // WEL clears on the first committed data byte; the burst continues
        xfer(1, 64'h06_00_00_00_00_00_00_00, rx, oef);
        cs_low();
        byte_x(8'h02, b, o);
        byte_x(8'h00, b, o);
        byte_x(8'h20, b, o);
        check("wel before data", 32'(wel), 32'd1);
        byte_x(8'h77, b, o);
        check("wel after first byte", 32'(wel), 32'd0);
        byte_x(8'h88, b, o);
        cs_high();
        xfer(5, 64'h03_00_20_00_00_00_00_00, rx, oef);
        check("burst byte0", 32'(rx[39:32]), 32'h77);
        check("burst byte1", 32'(rx[31:24]), 32'h88);

        // Partial byte at CS rise is discarded; next opcode decodes cleanly
        xfer(1, 64'h06_00_00_00_00_00_00_00, rx, oef);
        cs_low();
        byte_x(8'h02, b, o);
        byte_x(8'h00, b, o);
        byte_x(8'h30, b, o);
        bit_x(1'b0, m, o);
        bit_x(1'b0, m, o);
        bit_x(1'b1, m, o);
        bit_x(1'b1, m, o);
        cs_high();
        check("partial wel kept", 32'(wel), 32'd1);
        xfer(2, 64'h05_00_00_00_00_00_00_00, rx, oef);
        check("fresh opcode status", 32'(rx[55:48]), 32'h02);
        xfer(4, 64'h03_00_30_00_00_00_00_00, rx, oef);
        check("partial discarded", 32'(rx[39:32]), 32'hCA);

        // CS rise mid-READ drops MISO enable immediately
        cs_low();
        byte_x(8'h03, b, o);
        byte_x(8'h00, b, o);
        byte_x(8'h10, b, o);
        bit_x(1'b0, m, o);
        check("midread first bit", 32'(m), 32'd1);
        check("midread oe", 32'(o), 32'd1);
        bit_x(1'b0, m, o);
        bit_x(1'b0, m, o);
        #1;
        cs = 1'b1;
        #1;
        check("cs abort oe", 32'(miso_oe), 32'd0);
        check("cs abort miso", 32'(miso), 32'd0);
        #10;

        // Reset clears WEL but preserves memory
        xfer(1, 64'h06_00_00_00_00_00_00_00, rx, oef);
        check("wel set pre-reset", 32'(wel), 32'd1);
        rst_n = 1'b0;
        #5;
        check("reset clears wel", 32'(wel), 32'd0);
        rst_n = 1'b1;
        #5;
        xfer(4, 64'h03_00_10_00_00_00_00_00, rx, oef);
        check("mem kept over reset", 32'(rx[39:32]), 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
